// File: rtl/rsc_pkg.sv
// Shared definitions for the LTE constituent RSC encoder: FSM states,
// generator polynomials (bit i = coefficient of D^i) and trellis tail length.
package rsc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TERM = 2'd2
  } rsc_state_e;

  // g0 = 1 + D^2 + D^3 (feedback), g1 = 1 + D + D^3 (parity)
  localparam logic [3:0] G0_FB  = 4'b1101;
  localparam logic [3:0] G1_PAR = 4'b1011;

  localparam int TAIL_LEN = 3;

endpackage

// File: rtl/rsc_trellis_step.sv
// One combinational step of the RSC trellis. r_in/r_next pack {r3, r2, r1};
// tail_mode drives u from the feedback so the register flushes towards zero.
module rsc_trellis_step
  import rsc_pkg::*;
(
  input  logic       tail_mode,
  input  logic       u_in,
  input  logic [2:0] r_in,
  output logic       x_out,
  output logic       z_out,
  output logic [2:0] r_next
);

  logic fb;
  logic u;
  logic a;

  always_comb begin
    fb     = ^(r_in & G0_FB[3:1]);
    u      = tail_mode ? fb : u_in;
    a      = u ^ fb;
    x_out  = u;
    z_out  = (a & G1_PAR[0]) ^ (^(r_in & G1_PAR[3:1]));
    r_next = {r_in[1:0], a};
  end

endmodule

// File: rtl/lte_rsc_encoder.sv
// LTE constituent RSC encoder with ready/valid handshake and registered outputs.
// Define RSC_TERMINATION_EN to append the 3 trellis-termination pairs per frame.
module lte_rsc_encoder
  import rsc_pkg::*;
#(
  parameter int FL = 40
) (
  input  logic Clock,
  input  logic Reset,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic x_out,
  output logic z_out,
  output logic out_tail,
  output logic out_last
);

  localparam int CW = $clog2(FL + 1);

  rsc_state_e    state_q, state_d;
  logic [2:0]    r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    tail_cnt_q, tail_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          x_q, x_d;
  logic          z_q, z_d;
  logic          tail_q, tail_d;
  logic          last_q, last_d;

  logic          out_free;
  logic          accept;
  logic          tail_mode;
  logic [2:0]    step_r_in;
  logic [2:0]    step_r_next;
  logic          step_x;
  logic          step_z;
  logic [CW-1:0] cnt_cur;
  logic          final_bit;

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = !Reset && (state_q == IDLE || state_q == DATA) && out_free;
  assign accept    = in_valid && in_ready;
  assign tail_mode = (state_q == TERM);

  // A frame always starts from the zero state, even if the last one was not flushed
  assign step_r_in = (state_q == IDLE) ? 3'b000 : r_q;
  assign cnt_cur   = (state_q == IDLE) ? '0 : cnt_q;
  assign final_bit = ((cnt_cur + CW'(1)) == CW'(FL));

  rsc_trellis_step u_step (
    .tail_mode (tail_mode),
    .u_in      (in_bit),
    .r_in      (step_r_in),
    .x_out     (step_x),
    .z_out     (step_z),
    .r_next    (step_r_next)
  );

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    tail_cnt_d  = tail_cnt_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    z_d         = z_q;
    tail_d      = tail_q;
    last_d      = last_q;

    if (out_free) out_valid_d = 1'b0;

    case (state_q)
      IDLE, DATA: begin
        if (accept) begin
          out_valid_d = 1'b1;
          x_d         = step_x;
          z_d         = step_z;
          tail_d      = 1'b0;
          last_d      = 1'b0;
          r_d         = step_r_next;
          cnt_d       = cnt_cur + CW'(1);
          state_d     = DATA;
          if (final_bit) begin
`ifdef RSC_TERMINATION_EN
            state_d    = TERM;
            tail_cnt_d = '0;
`else
            state_d = IDLE;
            cnt_d   = '0;
            last_d  = 1'b1;
`endif
          end
        end
      end
      TERM: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          x_d         = step_x;
          z_d         = step_z;
          tail_d      = 1'b1;
          last_d      = (tail_cnt_q == 2'(TAIL_LEN - 1));
          r_d         = step_r_next;
          tail_cnt_d  = tail_cnt_q + 2'd1;
          if (tail_cnt_q == 2'(TAIL_LEN - 1)) begin
            state_d    = IDLE;
            cnt_d      = '0;
            tail_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      cnt_q       <= '0;
      tail_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      x_q         <= 1'b0;
      z_q         <= 1'b0;
      tail_q      <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      z_q         <= z_d;
      tail_q      <= tail_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign x_out     = x_q;
  assign z_out     = z_q;
  assign out_tail  = tail_q;
  assign out_last  = last_q;

endmodule
